weight_fifo: RTL and testbench
==============================

// Module: weight_fifo
// PURPOSE
//  Tile-granular weight FIFO feeding the weight-load path of the control unit and systolic array.
//  Accepts weight rows, one row per handshake, from the host/DRAM fetch side.
//  Exposes weight_fifo_valid_output only once a complete MUL_SIZE-row tile is buffered.
//  Streams that tile row-by-row on load_weights_i.
// PARAMETERS
//  MUL_SIZE   tpu_package::MUL_SIZE   rows per tile and weights per row (array dimension)
//  WEIGHT_W   8                       bits per weight
//  TILES      4                       tile capacity; DEPTH = TILES*MUL_SIZE rows (power of 2)
// PORTS
//  clk_i                     in   1                   clock
//  rst_i                     in   1                   asynchronous reset, active-low
//  flush_i                   in   1                   synchronous clear of all pointers/counters
//  wr_valid_i                in   1                   write row offered
//  wr_ready_o                out  1                   space for one row
//  wr_data_i                 in   MUL_SIZE*WEIGHT_W   weight row, weight 0 in LSBs
//  load_weights_i            in   1                   pop one row (from control unit)
//  weight_fifo_valid_output  out  1                   >=1 complete tile buffered
//  rd_data_o                 out  MUL_SIZE*WEIGHT_W   popped row
//  rd_valid_o                out  1                   rd_data_o valid this cycle
//  rd_tile_last_o            out  1                   rd_data_o is row MUL_SIZE-1 of its tile
//  err_o                     out  1                   sticky pop-underflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_i low, async): all pointers/counters 0. wr_ready_o=1, weight_fifo_valid_output=0.
//   rd_valid_o=0, rd_tile_last_o=0, err_o=0, rd_data_o=0. RAM contents are not cleared.
//  Write: row accepted when wr_valid_i && wr_ready_o; stored at wr_ptr; wr_ptr++ mod DEPTH.
//   wr_ready_o = (rows_used != DEPTH); comb from registered count.
//   wr_row_cnt counts 0..MUL_SIZE-1 and wraps. On the write of row MUL_SIZE-1, full_tiles++.
//  Read: pop when load_weights_i && weight_fifo_valid_output. Data is read at rd_ptr; rd_ptr++ mod DEPTH.
//   Read latency is 1 cycle: rd_data_o and rd_valid_o are registered and appear the cycle after the pop.
//   rd_row_cnt counts 0..MUL_SIZE-1. On the pop of row MUL_SIZE-1: full_tiles--, and
//   rd_tile_last_o=1 with that row.
//   A started tile always completes; weight_fifo_valid_output stays 1 until its last pop.
//  weight_fifo_valid_output = (full_tiles != 0), registered count, comb compare.
//   A partially written tile is never visible to the read side.
//  rows_used: +1 on write only, -1 on pop only, unchanged on a simultaneous write and pop.
//   Same rule for full_tiles on a tile completing and a tile draining in the same cycle.
//  Full with a simultaneous pop: wr_ready_o stays 0 that cycle. There is no pop-to-push bypass.
//  Pop request while weight_fifo_valid_output=0: ignored. No pointer move, rd_valid_o=0.
//  flush_i: same effect as reset except RAM; it has priority over a simultaneous write/pop that cycle.
//  Counter widths: pointers $clog2(DEPTH); rows_used $clog2(DEPTH)+1; full_tiles $clog2(TILES)+1.
// CONFIGURATION
//  WEIGHT_FIFO_ERR_EN defined: err_o sets on load_weights_i while weight_fifo_valid_output=0.
//   It also sets on wr_valid_i while wr_ready_o=0 for 2^16 consecutive cycles (stall watchdog).
//   err_o clears only on reset/flush_i.
//  Not defined: err_o tied 0; watchdog counter not instantiated.
// STRUCTURE
//  tpu_package: MUL_SIZE, WEIGHT_W, typedef logic [MUL_SIZE-1:0][WEIGHT_W-1:0] weight_row_t.
//  Sub-module weight_fifo_mem: simple dual-port RAM, DEPTH x weight_row_t.
//   One sync write port, one registered read port; BRAM-inferable.
//  weight_fifo holds pointers, row/tile counters and flag logic.
// TESTING
//  MUL_SIZE=8, TILES=4 assumed in all scenarios.
//  1 Write 8 rows (row k = all bytes k).
//    -> weight_fifo_valid_output rises the cycle after the 8th accept.
//    -> 8 pops give rows 0..7 with 1-cycle latency; rd_tile_last_o only on row 7.
//    -> weight_fifo_valid_output=0 after the last pop.
//  2 Write 7 rows -> weight_fifo_valid_output stays 0; load_weights_i ignored.
//    -> With WEIGHT_FIFO_ERR_EN: err_o=1 next cycle.
//  3 Write 32 rows without popping -> wr_ready_o=0 after the 32nd.
//    -> A 33rd wr_valid_i is not accepted; full_tiles=4.
//    -> One pop -> wr_ready_o=1 next cycle.
//  4 Steady state with continuous write and pop, 3 tiles resident.
//    -> full_tiles constant across the cycle where a tile completes as another drains.
//    -> Data order preserved across pointer wrap (>=64 rows streamed).
//  5 Assert rst_i low mid-tile (row 3 popped).
//    -> All outputs at reset values asynchronously.
//    -> After release, the next 8 writes form tile 0 and pops return them intact.
//  6 flush_i together with wr_valid_i and load_weights_i -> no write, no pop; empty next cycle.

Source files
------------

// File: rtl/tpu_package.sv
// Shared array dimensions and row type for the TPU datapath, plus a width helper
// that keeps one-entry structures from collapsing to zero-width counters.
package tpu_package;

  localparam int MUL_SIZE = 8;
  localparam int WEIGHT_W = 8;

  typedef logic [MUL_SIZE-1:0][WEIGHT_W-1:0] weight_row_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_fifo_mem.sv
// Simple dual-port row RAM: one synchronous write port and one registered read port.
// No reset on the array or the read register, so it maps onto block RAM.
module weight_fifo_mem
  import tpu_package::*;
#(
  parameter int DEPTH = 32,
  parameter int ROW_W = 64
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [cnt_w(DEPTH)-1:0] waddr,
  input  logic [ROW_W-1:0]        wdata,
  input  logic                    re,
  input  logic [cnt_w(DEPTH)-1:0] raddr,
  output logic [ROW_W-1:0]        q
);

  logic [ROW_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_fifo.sv
// Tile-granular weight FIFO: rows go in one at a time, but the read side only sees
// complete MUL_SIZE-row tiles. Define WEIGHT_FIFO_ERR_EN for the sticky err_o flag.
module weight_fifo #(
  parameter int MUL_SIZE = tpu_package::MUL_SIZE,
  parameter int WEIGHT_W = tpu_package::WEIGHT_W,
  parameter int TILES    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [MUL_SIZE*WEIGHT_W-1:0] wr_data_i,
  input  logic                         load_weights_i,
  output logic                         weight_fifo_valid_output,
  output logic [MUL_SIZE*WEIGHT_W-1:0] rd_data_o,
  output logic                         rd_valid_o,
  output logic                         rd_tile_last_o,
  output logic                         err_o
);

  localparam int ROW_W = MUL_SIZE * WEIGHT_W;
  localparam int DEPTH = TILES * MUL_SIZE;
  localparam int PW    = tpu_package::cnt_w(DEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = $clog2(TILES) + 1;
  localparam int RW    = tpu_package::cnt_w(MUL_SIZE);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(MUL_SIZE - 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    rows_used;
  logic [TW-1:0]    full_tiles;
  logic [RW-1:0]    wr_row_cnt;
  logic [RW-1:0]    rd_row_cnt;
  logic             rd_valid_q;
  logic             rd_last_q;
  logic [ROW_W-1:0] ram_q;

  logic push;
  logic pop;
  logic tile_done;
  logic tile_drain;

  // Handshakes: a write row transfers on a cycle where wr_valid_i and wr_ready_o are
  // both high; a pop transfers when load_weights_i and weight_fifo_valid_output are
  // both high, and its row appears on rd_data_o with rd_valid_o one cycle later.
  // flush_i suppresses both transfers in its cycle.
  assign wr_ready_o               = (rows_used != DEPTH_C);
  assign weight_fifo_valid_output = (full_tiles != '0);

  assign push       = wr_valid_i && wr_ready_o && !flush_i;
  assign pop        = load_weights_i && weight_fifo_valid_output && !flush_i;
  assign tile_done  = push && (wr_row_cnt == ROW_LAST);
  assign tile_drain = pop && (rd_row_cnt == ROW_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      wr_row_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      wr_row_cnt <= '0;
    end else if (push) begin
      wr_ptr     <= wr_ptr + 1'b1;
      wr_row_cnt <= tile_done ? '0 : wr_row_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr     <= '0;
      rd_row_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr     <= '0;
      rd_row_cnt <= '0;
    end else if (pop) begin
      rd_ptr     <= rd_ptr + 1'b1;
      rd_row_cnt <= tile_drain ? '0 : rd_row_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rows_used <= '0;
    end else if (flush_i) begin
      rows_used <= '0;
    end else begin
      case ({push, pop})
        2'b10:   rows_used <= rows_used + 1'b1;
        2'b01:   rows_used <= rows_used - 1'b1;
        default: rows_used <= rows_used;
      endcase
    end
  end

  // A tile completing and another draining in the same cycle leave the count alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_tiles <= '0;
    end else if (flush_i) begin
      full_tiles <= '0;
    end else begin
      case ({tile_done, tile_drain})
        2'b10:   full_tiles <= full_tiles + 1'b1;
        2'b01:   full_tiles <= full_tiles - 1'b1;
        default: full_tiles <= full_tiles;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else if (flush_i) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= pop;
      rd_last_q  <= tile_drain;
    end
  end

  weight_fifo_mem #(
    .DEPTH (DEPTH),
    .ROW_W (ROW_W)
  ) u_mem (
    .clk   (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data_i),
    .re    (pop),
    .raddr (rd_ptr),
    .q     (ram_q)
  );

  // The RAM read register has no reset; masking with rd_valid_q gives a zero output
  // after reset/flush without costing the block-RAM mapping.
  assign rd_data_o      = rd_valid_q ? ram_q : '0;
  assign rd_valid_o     = rd_valid_q;
  assign rd_tile_last_o = rd_last_q;

`ifdef WEIGHT_FIFO_ERR_EN
  logic [15:0] stall_cnt;
  logic        err_q;
  logic        stalled;

  assign stalled = wr_valid_i && !wr_ready_o;

  // Stall watchdog: the 2^16th consecutive refused write cycle raises the flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else if (flush_i) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (load_weights_i && !weight_fifo_valid_output) begin
        err_q <= 1'b1;
      end
      if (stalled) begin
        if (stall_cnt == 16'hFFFF) begin
          err_q <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_weight_fifo.sv
// Randomized self-checking bench for weight_fifo against a row-queue reference model.
module tb_weight_fifo;

  localparam int MS    = 8;
  localparam int WW    = 8;
  localparam int TILES = 4;
  localparam int DEPTH = TILES * MS;
  localparam int W     = MS * WW;

  // ---------------- clock / reset ----------------
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         wr_valid_i;
  logic         wr_ready_o;
  logic [W-1:0] wr_data_i;
  logic         load_weights_i;
  logic         weight_fifo_valid_output;
  logic [W-1:0] rd_data_o;
  logic         rd_valid_o;
  logic         rd_tile_last_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  weight_fifo #(
    .MUL_SIZE (MS),
    .WEIGHT_W (WW),
    .TILES    (TILES)
  ) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .flush_i                  (flush_i),
    .wr_valid_i               (wr_valid_i),
    .wr_ready_o               (wr_ready_o),
    .wr_data_i                (wr_data_i),
    .load_weights_i           (load_weights_i),
    .weight_fifo_valid_output (weight_fifo_valid_output),
    .rd_data_o                (rd_data_o),
    .rd_valid_o               (rd_valid_o),
    .rd_tile_last_o           (rd_tile_last_o),
    .err_o                    (err_o)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int           wr_tot;
  int           rd_tot;
  logic         m_err;
  int           m_stall;
  logic         exp_rd_valid;
  logic         exp_last;
  logic [W-1:0] exp_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    wr_tot       = 0;
    rd_tot       = 0;
    m_err        = 1'b0;
    m_stall      = 0;
    exp_rd_valid = 1'b0;
    exp_last     = 1'b0;
    exp_rd_data  = '0;
  endtask

  function automatic logic m_ready();
    return exp_q.size() != DEPTH;
  endfunction

  function automatic logic m_valid();
    return (wr_tot / MS - rd_tot / MS) != 0;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic ld, input logic fl);
    logic rdy, vld, push, pop;
    rdy = m_ready();
    vld = m_valid();
    check("wr_ready", W'(wr_ready_o), W'(rdy));
    check("fifo_valid", W'(weight_fifo_valid_output), W'(vld));
`ifdef WEIGHT_FIFO_ERR_EN
    check("err", W'(err_o), W'(m_err));
`else
    check("err_tied", W'(err_o), W'(1'b0));
`endif
    wr_valid_i     = wv;
    wr_data_i      = wd;
    load_weights_i = ld;
    flush_i        = fl;
    push = wv && rdy && !fl;
    pop  = ld && vld && !fl;
    if (fl) begin
      model_clear();
    end else begin
      if (ld && !vld) m_err = 1'b1;
      if (wv && !rdy) begin
        m_stall++;
        if (m_stall >= 65536) m_err = 1'b1;
      end else begin
        m_stall = 0;
      end
      exp_rd_valid = pop;
      exp_last     = 1'b0;
      if (pop) begin
        exp_rd_data = exp_q.pop_front();
        exp_last    = (rd_tot % MS) == MS - 1;
        rd_tot++;
      end
      if (push) begin
        exp_q.push_back(wd);
        wr_tot++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    wr_valid_i     = 1'b0;
    load_weights_i = 1'b0;
    flush_i        = 1'b0;
    check("rd_valid", W'(rd_valid_o), W'(exp_rd_valid));
    check("rd_tile_last", W'(rd_tile_last_o), W'(exp_last));
    if (exp_rd_valid) check("rd_data", rd_data_o, exp_rd_data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, W'(wr_ready_o), W'(1'b1));
    check({tag, "_fifo_valid"}, W'(weight_fifo_valid_output), W'(1'b0));
    check({tag, "_rd_valid"}, W'(rd_valid_o), W'(1'b0));
    check({tag, "_rd_last"}, W'(rd_tile_last_o), W'(1'b0));
    check({tag, "_rd_data"}, rd_data_o, '0);
    check({tag, "_err"}, W'(err_o), W'(1'b0));
  endtask

  function automatic logic [W-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] byte_row(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {MS{b}};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_i          = 1'b0;
    flush_i        = 1'b0;
    wr_valid_i     = 1'b0;
    wr_data_i      = '0;
    load_weights_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk_i);

    // One tile of byte-pattern rows, then drained row by row
    for (int k = 0; k < MS; k++) cycle(1'b1, byte_row(k), 1'b0, 1'b0);
    check("tile_visible", W'(weight_fifo_valid_output), W'(1'b1));
    for (int k = 0; k < MS; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("tile_drained", W'(weight_fifo_valid_output), W'(1'b0));

    // Partial tile stays invisible; pop attempt ignored
    for (int k = 0; k < MS - 1; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Fill to capacity, refused extra write, one pop frees a slot
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    check("full_ready", W'(wr_ready_o), W'(1'b0));
    cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("ready_after_pop", W'(wr_ready_o), W'(1'b1));

    // Finish the draining tile, then stream with 3 tiles resident across wraps
    for (int k = 0; k < MS - 1; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 80; k++) cycle(1'b1, rnd_row(), 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, rnd_row(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0);
    end

    // Async reset mid-tile (rows 0..3 popped)
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < MS; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    #2 rst_i = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    for (int k = 0; k < MS; k++) cycle(1'b1, byte_row(8'hA0 + k), 1'b0, 1'b0);
    for (int k = 0; k < MS; k++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush beats a simultaneous write and pop
    for (int k = 0; k < MS; k++) cycle(1'b1, rnd_row(), 1'b0, 1'b0);
    cycle(1'b1, rnd_row(), 1'b1, 1'b1);
    check_reset_outputs("flush");
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
